lcd_cmd_sequencer: RTL



---
 rtl/lcd_seq_pkg.sv | 41 ++++
 rtl/lcd_cmd_fifo.sv | 46 ++++
 rtl/lcd_cmd_sequencer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/lcd_seq_pkg.sv
// Shared types and command codes for the LCD command sequencer.
package lcd_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD  = 2'd2,
    S_WRITE = 2'd3
  } seq_state_t;

  typedef logic [3:0] lcd_cmd_t;

  localparam lcd_cmd_t CMD_WRITE     = 4'd0;
  localparam lcd_cmd_t CMD_UP        = 4'd1;
  localparam lcd_cmd_t CMD_DOWN      = 4'd2;
  localparam lcd_cmd_t CMD_LEFT      = 4'd3;
  localparam lcd_cmd_t CMD_RIGHT     = 4'd4;
  localparam lcd_cmd_t CMD_MAX       = 4'd5;
  localparam lcd_cmd_t CMD_MIN       = 4'd6;
  localparam lcd_cmd_t CMD_AVG       = 4'd7;
  localparam lcd_cmd_t CMD_ROT_CW    = 4'd8;
  localparam lcd_cmd_t CMD_ROT_CCW   = 4'd9;
  localparam lcd_cmd_t CMD_MIRX      = 4'd10;
  localparam lcd_cmd_t CMD_MIRY      = 4'd11;
  localparam lcd_cmd_t CMD_MAX_LEGAL = 4'd11;

  // Max/min/avg keep the controller busy for several cycles after issue.
  localparam lcd_cmd_t CMD_LONG_FIRST = CMD_MAX;
  localparam lcd_cmd_t CMD_LONG_LAST  = CMD_AVG;

  localparam int unsigned WDOG_W = 10;

  function automatic logic is_legal(input lcd_cmd_t c);
    return c <= CMD_MAX_LEGAL;
  endfunction

  function automatic logic is_long(input lcd_cmd_t c);
    return (c >= CMD_LONG_FIRST) && (c <= CMD_LONG_LAST);
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous command FIFO; AW+1-bit pointers distinguish full from empty.
module lcd_cmd_fifo
  import lcd_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  lcd_cmd_t push_data,
  input  logic     pop,
  output lcd_cmd_t head,
  output logic     full,
  output logic     empty
);

  lcd_cmd_t        mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  // A push while full is dropped even if a pop frees a slot in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// Issues queued host commands to the LCD controller one at a time and counts frames.
// Optional watchdog on S_HOLD/S_WRITE (adds err_wdog) when LCD_SEQ_WDOG_EN is defined.
module lcd_cmd_sequencer
  import lcd_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] host_cmd,
  input  logic       host_push,
  output logic       host_full,
  output logic       host_empty,
  input  logic       lcd_busy,
  input  logic       lcd_done,
  output logic [3:0] lcd_cmd,
  output logic       lcd_cmd_valid,
  output logic       frame_done,
  output logic [7:0] frame_cnt,
  output logic       err_ovf,
  output logic       err_bad
`ifdef LCD_SEQ_WDOG_EN
  ,
  output logic       err_wdog
`endif
);

  seq_state_t state;
  lcd_cmd_t   fifo_head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push_legal;
  logic       pop;

`ifdef LCD_SEQ_WDOG_EN
  logic [WDOG_W-1:0] wdog;
`endif

  assign push_legal = host_push && is_legal(host_cmd);
  assign pop        = (state == S_IDLE) && !fifo_empty && !lcd_busy;
  assign host_full  = fifo_full;
  assign host_empty = fifo_empty;

  lcd_cmd_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_legal),
    .push_data (host_cmd),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      lcd_cmd       <= '0;
      lcd_cmd_valid <= 1'b0;
      frame_done    <= 1'b0;
      frame_cnt     <= '0;
      err_ovf       <= 1'b0;
      err_bad       <= 1'b0;
`ifdef LCD_SEQ_WDOG_EN
      wdog          <= '0;
      err_wdog      <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      if (host_push && !is_legal(host_cmd)) err_bad <= 1'b1;
      if (push_legal && fifo_full)          err_ovf <= 1'b1;

      case (state)
        S_IDLE: begin
          if (pop) begin
            lcd_cmd       <= fifo_head;
            lcd_cmd_valid <= 1'b1;
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          lcd_cmd_valid <= 1'b0;
          state         <= (lcd_cmd == CMD_WRITE) ? S_WRITE : S_HOLD;
`ifdef LCD_SEQ_WDOG_EN
          wdog          <= '0;
`endif
        end
        S_HOLD: begin
          if (!lcd_busy) begin
            state <= S_IDLE;
`ifdef LCD_SEQ_WDOG_EN
          end else if (wdog == '1) begin
            state    <= S_IDLE;
            err_wdog <= 1'b1;
          end else begin
            wdog <= wdog + 1'b1;
`endif
          end
        end
        S_WRITE: begin
          if (lcd_done) begin
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 1'b1;
            state      <= S_IDLE;
`ifdef LCD_SEQ_WDOG_EN
          end else if (wdog == '1) begin
            state    <= S_IDLE;
            err_wdog <= 1'b1;
          end else begin
            wdog <= wdog + 1'b1;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
